dsp_event_sender: RTL and testbench

//  Transmit side of the DV/EV word protocol consumed by dspcontrol. Buffers hit words

---
 rtl/dsp_link_pkg.sv | 15 +
 rtl/sync_fifo.sv | 54 +++++
 rtl/dsp_event_sender.sv | 126 ++++++++++++
 tb/tb_dsp_event_sender.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dsp_link_pkg.sv
// Shared types and constants for the DV/EV word link towards the DSP fit chain.
package dsp_link_pkg;

  localparam int unsigned DW_DEF  = 32;
  localparam int unsigned EVCNT_W = 16;

  // Encodings are visible on state_out, so they are pinned explicitly.
  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StSend = 2'd1,
    StGap  = 2'd2,
    StDrop = 2'd3
  } state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with show-ahead read data; push ignored when full, pop ignored when empty.
module sync_fifo #(
  parameter int unsigned Width = 33,
  parameter int unsigned Aw    = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [Width-1:0] i_wdata,
  input  logic             i_pop,
  output logic [Width-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned  Depth   = 1 << Aw;
  localparam logic [Aw:0]  FullCnt = (Aw + 1)'(Depth);

  logic [Width-1:0] r_mem [Depth];
  logic [Aw-1:0]    r_wptr;
  logic [Aw-1:0]    r_rptr;
  logic [Aw:0]      r_cnt;
  logic             w_push;
  logic             w_pop;

  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_full  = (r_cnt == FullCnt);
  assign o_empty = (r_cnt == '0);
  assign o_rdata = r_mem[r_rptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/dsp_event_sender.sv
// Replays buffered hit words to the DSP chain as DV/EV beats with a fixed idle gap per event.
module dsp_event_sender #(
  parameter int unsigned DW         = dsp_link_pkg::DW_DEF,
  parameter int unsigned FIFO_AW    = 4,
  parameter int unsigned MAX_WORDS  = 64,
  parameter int unsigned GAP_CYCLES = 2
) (
  input  logic                               CLOCK,
  input  logic                               RESET,
  input  logic [DW-1:0]                      IN_DATA,
  input  logic                               IN_VALID,
  input  logic                               IN_LAST,
  output logic                               IN_READY,
  output logic [DW-1:0]                      DATA_OUT,
  output logic                               DV,
  output logic                               EV,
  output logic [dsp_link_pkg::EVCNT_W-1:0]   EVCOUNT,
  output logic                               TRUNC,
  output logic [1:0]                         state_out
);

  import dsp_link_pkg::*;

  localparam int unsigned    WCW   = $clog2(MAX_WORDS + 1);
  localparam int unsigned    GW    = $clog2(GAP_CYCLES + 1);
  localparam logic [WCW-1:0] WMax  = WCW'(MAX_WORDS);
  localparam logic [GW-1:0]  GLast = GW'(GAP_CYCLES - 1);

  logic               w_full;
  logic               w_empty;
  logic               w_pop;
  logic [DW:0]        w_rd_data;
  logic               w_rd_last;
  logic [DW-1:0]      w_rd_word;
  logic [WCW-1:0]     w_wcnt_nxt;

  state_e             r_state;
  logic [WCW-1:0]     r_wcnt;
  logic [GW-1:0]      r_gap;
  logic [DW-1:0]      r_data;
  logic               r_dv;
  logic               r_ev;
  logic [EVCNT_W-1:0] r_evcount;
  logic               r_trunc;

  // Ready is forced low while reset is held so nothing is accepted into a flushing FIFO.
  assign IN_READY   = ~w_full & ~RESET;
  assign w_pop      = ~w_empty & (r_state != StGap);
  assign w_rd_last  = w_rd_data[DW];
  assign w_rd_word  = w_rd_data[DW-1:0];
  assign w_wcnt_nxt = (r_state == StIdle) ? WCW'(1) : r_wcnt + WCW'(1);

  sync_fifo #(
    .Width (DW + 1),
    .Aw    (FIFO_AW)
  ) u_fifo (
    .i_clk   (CLOCK),
    .i_rst   (RESET),
    .i_push  (IN_VALID & IN_READY),
    .i_wdata ({IN_LAST, IN_DATA}),
    .i_pop   (w_pop),
    .o_rdata (w_rd_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Event FSM with word/gap counters and all registered outputs.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      r_state   <= StIdle;
      r_wcnt    <= '0;
      r_gap     <= '0;
      r_data    <= '0;
      r_dv      <= 1'b0;
      r_ev      <= 1'b0;
      r_evcount <= '0;
      r_trunc   <= 1'b0;
    end else begin
      r_dv <= 1'b0;
      r_ev <= 1'b0;
      unique case (r_state)
        StIdle, StSend: begin
          // An empty FIFO in StSend is a bubble: the event stays open indefinitely.
          if (!w_empty) begin
            r_data <= w_rd_word;
            r_dv   <= 1'b1;
            r_wcnt <= w_wcnt_nxt;
            if (w_rd_last || (w_wcnt_nxt == WMax)) begin
              r_ev      <= 1'b1;
              r_evcount <= r_evcount + 1'b1;
              r_gap     <= '0;
              if (w_rd_last) begin
                r_state <= StGap;
              end else begin
                r_trunc <= 1'b1;
                r_state <= StDrop;
              end
            end else begin
              r_state <= StSend;
            end
          end
        end
        StDrop: begin
          // Overlong event tail is discarded up to and including its last word.
          if (!w_empty && w_rd_last) begin
            r_gap   <= '0;
            r_state <= StGap;
          end
        end
        StGap: begin
          if (r_gap == GLast) r_state <= StIdle;
          else                r_gap   <= r_gap + 1'b1;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign DATA_OUT  = r_data;
  assign DV        = r_dv;
  assign EV        = r_ev;
  assign EVCOUNT   = r_evcount;
  assign TRUNC     = r_trunc;
  assign state_out = r_state;

endmodule

// File: tb/tb_dsp_event_sender.sv
// Self-checking bench: scoreboard of expected DV words plus table-driven and corner sequences.
module tb_dsp_event_sender;

  localparam int MAXW = 64;
  localparam int GAPC = 2;

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] IN_DATA = '0;
  logic        IN_VALID = 1'b0;
  logic        IN_LAST = 1'b0;
  logic        IN_READY;
  logic [31:0] DATA_OUT;
  logic        DV;
  logic        EV;
  logic [15:0] EVCOUNT;
  logic        TRUNC;
  logic [1:0]  state_out;

  dsp_event_sender #(
    .DW         (32),
    .FIFO_AW    (4),
    .MAX_WORDS  (MAXW),
    .GAP_CYCLES (GAPC)
  ) dut (
    .CLOCK     (CLOCK),
    .RESET     (RESET),
    .IN_DATA   (IN_DATA),
    .IN_VALID  (IN_VALID),
    .IN_LAST   (IN_LAST),
    .IN_READY  (IN_READY),
    .DATA_OUT  (DATA_OUT),
    .DV        (DV),
    .EV        (EV),
    .EVCOUNT   (EVCOUNT),
    .TRUNC     (TRUNC),
    .state_out (state_out)
  );

  always #5 CLOCK = ~CLOCK;

  typedef struct packed {logic ev; logic [31:0] d;} exp_t;
  typedef struct {logic [31:0] d; logic ev; int idle;} log_t;
  typedef struct {logic [31:0] d; logic last; int pause; logic exp_ev; int exp_idle;} vec_t;

  exp_t sb_q[$];
  log_t mon_log[$];
  exp_t mon_e;

  int   checks = 0;
  int   errors = 0;
  int   widx = 0;
  int   exp_evcnt = 0;
  logic exp_trunc = 1'b0;
  int   acc_cnt = 0;
  int   dv_cnt = 0;
  int   lows = 0;
  int   gap_left = 0;
  bit   full_chk = 0;
  bit   seen_full = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Reference behaviour for an accepted word: first MAX_WORDS words of an event go out,
  // EV on the last word or on the MAX_WORDS-th word, the rest is dropped.
  task automatic accept(input logic [31:0] d, input logic l);
    acc_cnt++;
    widx++;
    if (widx <= MAXW) begin
      sb_q.push_back({(l || widx == MAXW), d});
      if (l || widx == MAXW) exp_evcnt++;
      if (!l && widx == MAXW) exp_trunc = 1'b1;
    end
    if (l) widx = 0;
  endtask

  task automatic send(input logic [31:0] d, input logic l);
    bit acc = 0;
    IN_DATA  = d;
    IN_LAST  = l;
    IN_VALID = 1'b1;
    for (int n = 0; n < 2000 && !acc; n++) begin
      @(negedge CLOCK);
      acc = IN_READY;
      @(posedge CLOCK);
      #1;
    end
    IN_VALID = 1'b0;
    IN_LAST  = 1'b0;
    if (acc) accept(d, l);
    else     chk("send_accepted", acc, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge CLOCK);
      #1;
    end
  endtask

  task automatic drain();
    bit done = 0;
    for (int n = 0; n < 1000 && !done; n++) begin
      @(negedge CLOCK);
      #1;
      done = (sb_q.size() == 0) && (state_out == 2'd0) && !DV;
    end
    if (!done) chk("drain_done", done, 1);
    @(posedge CLOCK);
    #1;
  endtask

  // Output monitor: pops the scoreboard on every DV and enforces the post-EV idle gap.
  always @(negedge CLOCK) begin
    if (RESET) begin
      gap_left = 0;
      lows     = 0;
    end else begin
      if (EV) chk("ev_implies_dv", DV, 1);
      if (DV) begin
        dv_cnt++;
        chk("gap_respected", gap_left, 0);
        if (sb_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_dv: got data 0x%0h, required no output", DATA_OUT);
        end else begin
          mon_e = sb_q.pop_front();
          chk("dv_data", DATA_OUT, mon_e.d);
          chk("dv_ev", EV, mon_e.ev);
        end
        mon_log.push_back('{d: DATA_OUT, ev: EV, idle: lows});
        lows     = 0;
        gap_left = EV ? GAPC : 0;
      end else begin
        lows++;
        if (gap_left > 0) gap_left--;
      end
      if (full_chk && !IN_READY && !seen_full) begin
        seen_full = 1;
        chk("full_level", acc_cnt - dv_cnt, 16);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  vec_t tbl[8];

  initial begin
    // A,B,C back-to-back; two single-word events; D,E, 3-cycle pause, F.
    tbl[0] = '{32'hA000_0001, 1'b0, 0,  1'b0, -1};
    tbl[1] = '{32'hB000_0002, 1'b0, 0,  1'b0, 0};
    tbl[2] = '{32'hC000_0003, 1'b1, 0,  1'b1, 0};
    tbl[3] = '{32'h1111_1111, 1'b1, 0,  1'b1, 2};
    tbl[4] = '{32'h2222_2222, 1'b1, 10, 1'b1, 2};
    tbl[5] = '{32'hD000_0004, 1'b0, 0,  1'b0, -1};
    tbl[6] = '{32'hE000_0005, 1'b0, 3,  1'b0, 0};
    tbl[7] = '{32'hF000_0006, 1'b1, 0,  1'b1, 3};

    // Reset state
    repeat (3) @(negedge CLOCK);
    chk("rst_dv", DV, 0);
    chk("rst_ev", EV, 0);
    chk("rst_evcount", EVCOUNT, 0);
    chk("rst_trunc", TRUNC, 0);
    chk("rst_state", state_out, 0);
    chk("rst_data", DATA_OUT, 0);
    chk("rst_ready", IN_READY, 0);
    RESET = 1'b0;
    #1;
    chk("ready_after_rst", IN_READY, 1);
    @(posedge CLOCK);
    #1;

    // Tests 1-3 from the table
    mon_log.delete();
    for (int i = 0; i < 8; i++) begin
      send(tbl[i].d, tbl[i].last);
      idle(tbl[i].pause);
    end
    drain();
    chk("t123_count", mon_log.size(), 8);
    for (int i = 0; i < 8 && i < mon_log.size(); i++) begin
      chk($sformatf("t123_data[%0d]", i), mon_log[i].d, tbl[i].d);
      chk($sformatf("t123_ev[%0d]", i), mon_log[i].ev, tbl[i].exp_ev);
      if (tbl[i].exp_idle >= 0)
        chk($sformatf("t123_idle[%0d]", i), mon_log[i].idle, tbl[i].exp_idle);
    end
    chk("t123_evcount", EVCOUNT, exp_evcnt);
    chk("t123_trunc", TRUNC, exp_trunc);

    // Exactly MAX_WORDS with last on the final word: normal end, no truncation
    mon_log.delete();
    for (int i = 1; i <= MAXW; i++) send(32'h6400_0000 + i, i == MAXW);
    drain();
    chk("max_count", mon_log.size(), MAXW);
    chk("max_trunc", TRUNC, exp_trunc);
    chk("max_evcount", EVCOUNT, exp_evcnt);

    // Test 4: 70-word event truncated at 64, following event normal
    mon_log.delete();
    for (int i = 1; i <= 70; i++) send(32'h7000_0000 + i, i == 70);
    send(32'h7100_0001, 1'b0);
    send(32'h7100_0002, 1'b1);
    drain();
    chk("trunc_count", mon_log.size(), MAXW + 2);
    if (mon_log.size() >= MAXW) chk("trunc_ev64", mon_log[MAXW-1].ev, 1);
    chk("trunc_sticky", TRUNC, exp_trunc);
    chk("trunc_evcount", EVCOUNT, exp_evcnt);

    // Test 5: single-word events outrun the sender (1 pop per GAP_CYCLES+1), FIFO fills
    mon_log.delete();
    acc_cnt  = 0;
    dv_cnt   = 0;
    full_chk = 1;
    for (int i = 0; i < 40; i++) send(32'h5000_0000 + i, 1'b1);
    drain();
    full_chk = 0;
    chk("full_seen", seen_full, 1);
    chk("full_count", mon_log.size(), 40);
    chk("full_evcount", EVCOUNT, exp_evcnt);

    // Test 6: reset after 2 of 5 words of an event are on DV
    mon_log.delete();
    send(32'h6666_0000, 1'b1);
    for (int i = 1; i <= 5; i++) send(32'h6600_0000 + i, i == 5);
    for (int n = 0; n < 50 && mon_log.size() < 3; n++) begin
      @(negedge CLOCK);
      #1;
    end
    chk("t6_progress", mon_log.size(), 3);
    #2;
    RESET = 1'b1;
    #1;
    chk("t6_dv", DV, 0);
    chk("t6_ev", EV, 0);
    chk("t6_evcount", EVCOUNT, 0);
    chk("t6_state", state_out, 0);
    chk("t6_ready", IN_READY, 0);
    sb_q.delete();
    widx      = 0;
    exp_evcnt = 0;
    exp_trunc = 1'b0;
    chk("t6_trunc", TRUNC, exp_trunc);
    @(negedge CLOCK);
    RESET = 1'b0;
    mon_log.delete();
    idle(4);
    chk("t6_no_stale", mon_log.size(), 0);
    send(32'h7777_0001, 1'b0);
    send(32'h7777_0002, 1'b1);
    drain();
    chk("t6_count", mon_log.size(), 2);
    chk("t6_evcount_after", EVCOUNT, exp_evcnt);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
